risc16_trace_tx: RTL and testbench
==================================

Name: risc16_trace_tx

Overview:
Commit-trace transmitter for the RiSC-16 core. It is the on-chip producer of the per-instruction state that benches currently probe hierarchically: PC, instruction, register writeback enable, destination and data. Each retired instruction is captured as a record, buffered in a small FIFO, and serialized as 8-byte frames on a byte-wide valid/ready stream. The stream feeds a debug link or a bench-side trace receiver. Sits beside risc16_processor and is driven by its writeback-stage signals.

Parameters:
DEPTH, 4, record FIFO depth; power of 2, ≥2
SYNC_BYTE, 8'hA5, frame header byte

Ports:
clk  in  1  core clock; all logic on posedge
rst  in  1  synchronous reset, active-high
trace_en  in  1  capture enable; low = commits ignored, queued frames still drain
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  16  PC of retiring instruction
commit_instr  in  16  retiring instruction word
commit_we  in  1  register-file write enable (WE_rf)
commit_rd  in  3  destination register
commit_wdata  in  16  writeback value
tx_valid  out  1  tx_data holds a valid byte
tx_data  out  8  trace byte
tx_ready  in  1  downstream accepts byte when tx_valid && tx_ready at posedge
clear_ovf  in  1  single-cycle pulse; clears overflow and drop_count
overflow  out  1  sticky; a record was dropped
drop_count  out  8  dropped records, saturates at 255
busy  out  1  FIFO non-empty or frame in flight

Behaviour:
- Reset (rst=1 at posedge): FIFO emptied, seq=0, FSM=IDLE, tx_valid=0, tx_data=0, overflow=0, drop_count=0, busy=0. Reset mid-frame aborts the frame; no completion bytes are sent.
- Capture: at posedge with commit_valid && trace_en, record {seq, we, rd, pc, instr, wdata} is written.
  - wdata is stored as 0 when commit_we=0.
  - seq is a 4-bit counter; it increments only on an accepted record and wraps 15→0.
- Full FIFO: record accepted if FIFO not full, or if the serializer pops in the same cycle. Otherwise dropped: overflow←1, drop_count+1 (saturating), seq unchanged.
- clear_ovf coincident with a drop: the clear wins; the result is overflow=0, drop_count=0.
- Frame byte order:
  - B0 SYNC_BYTE
  - B1 {we, rd[2:0], seq[3:0]}
  - B2 pc[15:8], B3 pc[7:0]
  - B4 instr[15:8], B5 instr[7:0]
  - B6 wdata[15:8], B7 wdata[7:0]
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the frame register, idx←0, go to SEND.
  - SEND: tx_valid=1, tx_data=byte[idx].
    - On a handshake with idx<7: idx+1.
    - On a handshake with idx=7: if FIFO non-empty, pop the next record, idx←0, stay in SEND (back-to-back frames, no bubble). Otherwise go to IDLE.
- Latency: commit_valid sampled at the end of cycle k → tx_valid=1, tx_data=SYNC in cycle k+2 (FIFO empty, FSM IDLE). Sustained throughput is 1 byte/cycle with tx_ready held high.
- Stream rules:
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - tx_valid never depends combinationally on tx_ready.
  - tx_valid deasserts only after the B7 handshake with the FIFO empty.
- trace_en low does not flush the FIFO or stall the serializer.
- busy = FIFO non-empty || FSM==SEND.

Test Plan:
- Single commit: pc=0x0004, instr=0x2481, we=1, rd=2, wdata=0x00FF, tx_ready=1 → bytes A5,A0,00,04,24,81,00,FF. First byte in cycle k+2, then 8 consecutive cycles, then tx_valid=0 and busy=0.
- Backpressure: same record, tx_ready toggling 1,0,0,1,… → every byte held stable while stalled. Frame content is unchanged; 8 handshakes in total.
- Sequence and we=0: 17 commits, the last with we=0 and wdata=0x1234 → B1 low nibbles run 0..F then 0. The last frame has B1[7]=0 and B6,B7=00,00.
- Overflow: DEPTH=4, tx_ready=0, 7 consecutive commits → 5 accepted (4 queued + 1 in the frame register), 2 dropped. overflow=1, drop_count=2. Then clear_ovf → both 0; releasing tx_ready drains 5 frames with seq 0..4.
- trace_en low: 3 commits with trace_en=0 → no frames, seq unchanged, busy=0.
- Reset mid-frame: rst asserted after B3 handshake → next cycle tx_valid=0, busy=0, FIFO empty. A new commit afterwards produces a frame with seq=0.

Source files
------------

// File: rtl/risc16_trace_tx.sv
// risc16_trace_tx: captures retired-instruction records into a FIFO and streams them as 8-byte frames
module risc16_trace_tx #(
    parameter int DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trace_en,
    input  logic        commit_valid,
    input  logic [15:0] commit_pc,
    input  logic [15:0] commit_instr,
    input  logic        commit_we,
    input  logic [2:0]  commit_rd,
    input  logic [15:0] commit_wdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        clear_ovf,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nxt;
    logic [55:0] mem [DEPTH];
    logic [55:0] frame;
    logic [7:0][7:0] bytes;
    logic [AW:0] wr_ptr, rd_ptr;
    logic [3:0] seq;
    logic [2:0] idx;
    logic empty, full, hs, pop, cap, push;
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign hs    = state == SEND && tx_ready;
    assign pop   = !empty && (state == IDLE || (hs && idx == 3'd7));
    assign cap   = commit_valid && trace_en;
    assign push  = cap && (!full || pop);
    assign bytes = {SYNC_BYTE, frame[51:48], frame[55:52], frame[47:0]};
    // record storage; layout {seq, we, rd, pc, instr, wdata}
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {seq, commit_we, commit_rd, commit_pc, commit_instr, commit_we ? commit_wdata : 16'h0};
    end
    // FIFO pointers, sequence counter and drop accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            seq <= 4'd0;
            overflow <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
                seq <= seq + 4'd1;
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (clear_ovf) begin
                overflow <= 1'b0;
                drop_count <= 8'd0;
            end else if (cap && !push) begin
                overflow <= 1'b1;
                drop_count <= drop_count + {7'd0, drop_count != 8'hFF};
            end
        end
    end
    // serializer state, frame register and byte index
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            frame <= '0;
            idx <= 3'd0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                frame <= mem[rd_ptr[AW-1:0]];
                idx <= 3'd0;
            end else if (hs) begin
                idx <= idx + 3'd1;
            end
        end
    end
    // leave SEND only after the last byte goes out with nothing queued
    always_comb begin
        state_nxt = state == IDLE ? (empty ? IDLE : SEND) : (hs && idx == 3'd7 && empty ? IDLE : SEND);
    end
    // stream outputs depend only on registered state, never on tx_ready
    always_comb begin
        tx_valid = state == SEND;
        tx_data  = tx_valid ? bytes[3'd7 - idx] : 8'h0;
        busy     = !empty || state == SEND;
    end
endmodule

// File: tb/tb_risc16_trace_tx.sv
// tb_risc16_trace_tx: directed vector bench for the commit-trace transmitter
module tb_risc16_trace_tx;
    logic clk, rst, trace_en, commit_valid, commit_we, tx_valid, tx_ready, clear_ovf, overflow, busy;
    logic [15:0] commit_pc, commit_instr, commit_wdata;
    logic [2:0] commit_rd;
    logic [7:0] tx_data, drop_count;
    int checks = 0, errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        we;
        logic [2:0]  rd;
        logic [15:0] wdata;
        logic [63:0] exp;
    } vec_t;
    vec_t vt[4];

    risc16_trace_tx #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_instr(commit_instr), .commit_we(commit_we),
        .commit_rd(commit_rd), .commit_wdata(commit_wdata), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .clear_ovf(clear_ovf),
        .overflow(overflow), .drop_count(drop_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // stalled bytes must hold until accepted
    logic pv = 1'b0, pr = 1'b1, prst = 1'b1;
    logic [7:0] pd = 8'h0;
    always @(negedge clk) begin
        if (pv && !pr && !prst) chk("stall_hold", {tx_valid, tx_data}, {1'b1, pd});
        pv = tx_valid; pr = tx_ready; pd = tx_data; prst = rst;
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic commit(input logic [15:0] pc, input logic [15:0] instr, input logic we,
                          input logic [2:0] rd, input logic [15:0] wdata);
        commit_valid = 1'b1; commit_pc = pc; commit_instr = instr;
        commit_we = we; commit_rd = rd; commit_wdata = wdata;
        @(negedge clk);
        commit_valid = 1'b0;
    endtask

    task automatic get_frame(input logic bp, output logic [63:0] f, output int cyc);
        logic [3:0] pat = 4'b1001;
        int n = 0;
        f = '0;
        cyc = 0;
        while (n < 8 && cyc < 200) begin
            if (tx_valid && tx_ready) begin
                f = {f[55:0], tx_data};
                n++;
            end
            cyc++;
            if (bp) tx_ready = pat[cyc[1:0]];
            @(negedge clk);
        end
        tx_ready = 1'b1;
        if (n < 8) chk("frame_timeout", 64'(n), 64'd8);
    endtask

    initial begin
        logic [63:0] f;
        int cyc;
        logic [15:0] pcv;
        logic wev;
        vt[0] = '{16'h0004, 16'h2481, 1'b1, 3'd2, 16'h00FF, 64'hA5A0_0004_2481_00FF};
        vt[1] = '{16'h1234, 16'hABCD, 1'b0, 3'd7, 16'hFFFF, 64'hA571_1234_ABCD_0000};
        vt[2] = '{16'hFFFE, 16'h8001, 1'b1, 3'd0, 16'h8000, 64'hA582_FFFE_8001_8000};
        vt[3] = '{16'h0100, 16'h0000, 1'b1, 3'd5, 16'hDEAD, 64'hA5D3_0100_0000_DEAD};
        rst = 1'b1; trace_en = 1'b1; commit_valid = 1'b0; commit_pc = '0; commit_instr = '0;
        commit_we = 1'b0; commit_rd = '0; commit_wdata = '0; tx_ready = 1'b1; clear_ovf = 1'b0;
        @(negedge clk);
        do_reset();
        chk("reset_state", {tx_valid, tx_data, overflow, drop_count, busy}, '0);

        for (int i = 0; i < 4; i++) begin
            commit(vt[i].pc, vt[i].instr, vt[i].we, vt[i].rd, vt[i].wdata);
            chk("lat_k1_idle", {63'd0, tx_valid}, 64'd0);
            @(negedge clk);
            chk("lat_k2_sync", {tx_valid, tx_data}, {1'b1, 8'hA5});
            get_frame(1'b0, f, cyc);
            chk("vec_frame", f, vt[i].exp);
            chk("vec_cycles", 64'(cyc), 64'd8);
            chk("vec_done", {tx_valid, busy}, 2'b00);
        end

        do_reset();
        commit(vt[0].pc, vt[0].instr, vt[0].we, vt[0].rd, vt[0].wdata);
        @(negedge clk);
        get_frame(1'b1, f, cyc);
        chk("bp_frame", f, vt[0].exp);
        chk("bp_stalled", 64'(cyc > 8), 64'd1);
        chk("bp_done", {tx_valid, busy}, 2'b00);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            pcv = 16'(i);
            wev = i != 16;
            commit(pcv, 16'h1000, wev, 3'd1, i == 16 ? 16'h1234 : 16'h5555);
            @(negedge clk);
            get_frame(1'b0, f, cyc);
            chk("seq_frame", f, {8'hA5, wev, 3'd1, 4'(i), pcv, 16'h1000, wev ? 16'h5555 : 16'h0000});
        end

        do_reset();
        tx_ready = 1'b0;
        commit_valid = 1'b1; commit_we = 1'b1; commit_rd = 3'd3; commit_instr = 16'h6000; commit_wdata = 16'h0042;
        for (int i = 0; i < 7; i++) begin
            commit_pc = 16'(16'h0100 + i);
            @(negedge clk);
        end
        chk("ovf_after7", {overflow, drop_count}, {1'b1, 8'd2});
        for (int i = 0; i < 260; i++) @(negedge clk);
        chk("ovf_saturate", {overflow, drop_count}, {1'b1, 8'd255});
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        commit_valid = 1'b0;
        chk("clear_wins", {overflow, drop_count}, '0);
        @(negedge clk);
        chk("clear_stays", {overflow, drop_count, busy}, {9'd0, 1'b1});
        tx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            get_frame(1'b0, f, cyc);
            chk("drain_frame", f, {8'hA5, 1'b1, 3'd3, 4'(i), 16'(16'h0100 + i), 16'h6000, 16'h0042});
            chk("drain_b2b", 64'(cyc), 64'd8);
        end
        chk("drain_done", {tx_valid, busy}, 2'b00);

        trace_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            commit(16'h0F00, 16'h1111, 1'b1, 3'd6, 16'h2222);
            @(negedge clk);
            chk("en_low_idle", {tx_valid, busy}, 2'b00);
        end
        trace_en = 1'b1;
        commit(16'h0BAD, 16'hC0DE, 1'b1, 3'd4, 16'h0001);
        @(negedge clk);
        get_frame(1'b0, f, cyc);
        chk("en_seq_kept", f, 64'hA5C5_0BAD_C0DE_0001);

        commit(vt[1].pc, vt[1].instr, vt[1].we, vt[1].rd, vt[1].wdata);
        commit(vt[2].pc, vt[2].instr, vt[2].we, vt[2].rd, vt[2].wdata);
        for (int i = 0; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_frame", {tx_valid, busy}, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_fifo_empty", {tx_valid, busy}, 2'b00);
        commit(vt[0].pc, vt[0].instr, vt[0].we, vt[0].rd, vt[0].wdata);
        @(negedge clk);
        get_frame(1'b0, f, cyc);
        chk("rst_seq0", f, vt[0].exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
